// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared pipeline types and widths for the data-memory responder
package dmem_responder_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: synchronous write, registered read, contents never reset
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // write port and registered read port; read word only changes when re is set
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder; DMEM_RANGE_CHECK_EN adds resp_err
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              resp_err
`endif
);

  localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              err_out_q;
  logic              accept;
  logic              err_in;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              arr_we;
  logic              arr_re;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

`ifdef DMEM_RANGE_CHECK_EN
  assign err_in   = ((req_addr >> ADDR_W) != 16'd0);
  assign resp_err = err_out_q;
`else
  logic unused_addr_hi;
  logic unused_err;
  assign err_in         = 1'b0;
  assign unused_addr_hi = |(req_addr >> ADDR_W);
  assign unused_err     = err_out_q;
`endif

  // state register; reset aborts any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: accept -> wait states -> single access cycle -> hold response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (WAIT > 0) ? WAITST : ACCESS;
      WAITST:  if (cnt_q == '0) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request capture on acceptance and wait-state countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= WAIT_INIT;
      we_q    <= req_we;
      addr_q  <= req_addr[ADDR_W-1:0];
      wdata_q <= req_wdata;
      err_q   <= err_in;
    end else if (state_q == WAITST && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // the read is launched on the edge entering ACCESS so the word is ready during ACCESS;
  // in IDLE the latched address is not yet loaded, so read straight from the request
  assign rd_addr = (state_q == IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
  assign arr_re  = (state_d == ACCESS);
  assign arr_we  = (state_q == ACCESS) && we_q && !err_q;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (arr_re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // response data/err registered at the end of ACCESS, held through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      err_out_q  <= 1'b0;
    end else if (state_q == ACCESS) begin
      resp_rdata <= err_q ? '0 : (we_q ? wdata_q : rd_data);
      err_out_q  <= err_q;
    end else if (state_q == RESP && resp_ready) begin
      err_out_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WAIT=2 and WAIT=0)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        resp_ready = 1'b1;
  logic        req_ready, req_ready0;
  logic        resp_valid, resp_valid0;
  logic [15:0] resp_rdata, resp_rdata0;
`ifdef DMEM_RANGE_CHECK_EN
  logic        resp_err, resp_err0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .resp_err   (resp_err)
`endif
  );

  dmem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid0),
    .req_ready  (req_ready0),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid0),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata0)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .resp_err   (resp_err0)
`endif
  );

  // one request with resp_ready high; lat counts cycles from the accept cycle to resp_valid
  task automatic issue(input bit sel0, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, output int lat, output logic [15:0] data,
                       output logic err);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
    if (sel0) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    err = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!(sel0 ? resp_valid0 : resp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!(sel0 ? resp_valid0 : resp_valid)) lat = 99;
    data = sel0 ? resp_rdata0 : resp_rdata;
`ifdef DMEM_RANGE_CHECK_EN
    err = sel0 ? resp_err0 : resp_err;
`endif
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_checks++;
    if (resp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0000", resp_rdata); end
    n_checks++;
    if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_dut0 got valid=%b ready=%b want 0/1", resp_valid0, req_ready0);
    end
  endtask

  task automatic test_store_load;
    int lat; logic [15:0] d; logic e;
    issue(1'b0, 1'b1, 16'h0012, 16'hBEEF, lat, d, e);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL store_latency got %0d want 4", lat); end
    n_checks++;
    if (d !== 16'hBEEF) begin n_fail++; $display("FAIL store_rdata got %h want beef", d); end
    issue(1'b0, 1'b0, 16'h0012, 16'h0000, lat, d, e);
    n_checks++;
    if (d !== 16'hBEEF || lat !== 4) begin n_fail++; $display("FAIL load_0012 got %h lat %0d want beef lat 4", d, lat); end
`ifndef DMEM_RANGE_CHECK_EN
    issue(1'b0, 1'b0, 16'h0112, 16'h0000, lat, d, e);
    n_checks++;
    if (d !== 16'hBEEF) begin n_fail++; $display("FAIL load_wrap_0112 got %h want beef", d); end
`endif
    issue(1'b0, 1'b1, 16'h0013, 16'h0F0F, lat, d, e);
    issue(1'b0, 1'b0, 16'h0013, 16'h0000, lat, d, e);
    n_checks++;
    if (d !== 16'h0F0F) begin n_fail++; $display("FAIL load_0013 got %h want 0f0f", d); end
  endtask

  task automatic test_stall;
    int lat; logic [15:0] d; logic e; int guard;
    issue(1'b0, 1'b1, 16'h0021, 16'h7777, lat, d, e);
    @(negedge clk);
    resp_ready = 1'b0; req_we = 1'b0; req_addr = 16'h0021; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 16'h7777) begin
      n_fail++; $display("FAIL stall_first got valid=%b data=%h want 1/7777", resp_valid, resp_rdata);
    end
    req_valid = 1'b1; req_we = 1'b1; req_wdata = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 16'h7777 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got valid=%b data=%h ready=%b want 1/7777/0", i, resp_valid, resp_rdata, req_ready);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
    issue(1'b0, 1'b0, 16'h0021, 16'h0000, lat, d, e);
    n_checks++;
    if (d !== 16'h7777) begin n_fail++; $display("FAIL stall_ignored_store got %h want 7777", d); end
  endtask

  task automatic test_wait0;
    int lat; logic [15:0] d; logic e;
    issue(1'b1, 1'b1, 16'h0040, 16'hA5A5, lat, d, e);
    n_checks++;
    if (lat !== 2 || d !== 16'hA5A5) begin n_fail++; $display("FAIL wait0_store got lat %0d data %h want 2/a5a5", lat, d); end
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, lat, d, e);
    n_checks++;
    if (lat !== 2 || d !== 16'hA5A5) begin n_fail++; $display("FAIL wait0_load got lat %0d data %h want 2/a5a5", lat, d); end
  endtask

  // hold req_valid high with resp_ready high and measure spacing of accepts
  task automatic test_back_to_back(input bit sel0, input int period);
    int acc [4]; int n;
    n = 0;
    @(negedge clk);
    resp_ready = 1'b1; req_we = 1'b0; req_addr = 16'h0012;
    if (sel0) req_valid0 = 1'b1; else req_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if ((sel0 ? req_ready0 : req_ready) && n < 4) begin acc[n] = c; n++; end
      @(negedge clk);
    end
    req_valid = 1'b0; req_valid0 = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL b2b_count_w%0d got %0d want 4", period, n);
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (acc[k] - acc[k-1] !== period) begin
          n_fail++; $display("FAIL b2b_interval_w%0d[%0d] got %0d want %0d", period, k, acc[k] - acc[k-1], period);
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [15:0] d; logic e; int seen;
    issue(1'b0, 1'b1, 16'h0005, 16'h1111, lat, d, e);
    @(negedge clk);
    req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'h1234; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_reset got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp got %0d valid cycles want 0", seen); end
    issue(1'b0, 1'b0, 16'h0005, 16'h0000, lat, d, e);
    n_checks++;
    if (d !== 16'h1111) begin n_fail++; $display("FAIL abort_mem5 got %h want 1111", d); end
  endtask

`ifdef DMEM_RANGE_CHECK_EN
  task automatic test_range_check;
    int lat; logic [15:0] d; logic e;
    issue(1'b0, 1'b1, 16'h0000, 16'h2222, lat, d, e);
    issue(1'b0, 1'b1, 16'h0100, 16'hABCD, lat, d, e);
    n_checks++;
    if (e !== 1'b1 || d !== 16'h0000 || lat !== 4) begin
      n_fail++; $display("FAIL range_err got err=%b data=%h lat=%0d want 1/0000/4", e, d, lat);
    end
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, lat, d, e);
    n_checks++;
    if (e !== 1'b0 || d !== 16'h2222) begin
      n_fail++; $display("FAIL range_mem0 got err=%b data=%h want 0/2222", e, d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_stall();
    test_wait0();
    test_back_to_back(1'b1, 3);
    test_back_to_back(1'b0, 5);
    test_reset_abort();
`ifdef DMEM_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
